// File: rtl/mpu_bus_master.sv
// mpu_bus_master
//   Host-side initiator for the ChronoCube MPU bus. Converts a valid/ready
//   command stream into timed, active-low bus cycles and returns read data
//   as a one-cycle response pulse.
//
//   Optional feature macro: MPU_MASTER_AUTOINC_EN
//     When defined, the cmd_inc port exists. A command accepted with
//     cmd_inc = 1 uses (last address + 1) instead of cmd_addr.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accept when both high)
//   cmd_write             1 = write, 0 = read
//   cmd_addr/data/be      command address, write data, byte enables (active high)
//   cmd_inc               auto-increment request (MPU_MASTER_AUTOINC_EN only)
//   rsp_valid/rsp_data    one-cycle completion pulse with read data (0 for writes)
//   busy                  transaction in progress (= ~cmd_ready)
//   _mpu_en/_mpu_rd/_mpu_wr/_mpu_be   active-low bus controls, all registered
//   mpu_addr/mpu_data_out registered address and write data
//   mpu_data_in           read data from the chip
module mpu_bus_master #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [1:0]            cmd_be,
`ifdef MPU_MASTER_AUTOINC_EN
  input  logic                  cmd_inc,
`endif
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  _mpu_en,
  output logic                  _mpu_rd,
  output logic                  _mpu_wr,
  output logic [1:0]            _mpu_be,
  output logic [ADDR_WIDTH-1:0] mpu_addr,
  output logic [DATA_WIDTH-1:0] mpu_data_out,
  input  logic [DATA_WIDTH-1:0] mpu_data_in
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // A strobe of zero length makes no bus cycle, so it is stretched to one.
  localparam int unsigned STB_EFF  = (STROBE_CYCLES == 0) ? 1 : STROBE_CYCLES;
  // Counter reload values: a state lasting N cycles counts N-1 down to 0.
  localparam logic [3:0]  SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0]  STB_LD   = 4'(STB_EFF - 1);
  localparam logic [3:0]  HOLD_LD  = 4'(HOLD_CYCLES - 1);

  state_t                state, state_d;
  logic [3:0]            cnt, cnt_d;
  logic                  wr_lat, wr_d;
  logic [1:0]            be_lat, be_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  accept, strobe_end;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_comb begin
    state_d    = state;
    cnt_d      = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    accept     = 1'b0;
    strobe_end = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (SETUP_CYCLES != 0) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = STROBE;
            cnt_d   = STB_LD;
          end
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STB_LD;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          strobe_end = 1'b1;
          if (HOLD_CYCLES != 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (cnt == 4'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle view of the latched command, so the registered bus outputs
  // switch on the same edge that accepts the command.
  assign wr_d = accept ? cmd_write : wr_lat;
  assign be_d = accept ? cmd_be    : be_lat;

`ifdef MPU_MASTER_AUTOINC_EN
  // mpu_addr still holds the previous transaction's address (0 after reset).
  assign addr_d = cmd_inc ? mpu_addr + ADDR_WIDTH'(1) : cmd_addr;
`else
  assign addr_d = cmd_addr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wr_lat <= 1'b0;
      be_lat <= 2'b00;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        wr_lat <= cmd_write;
        be_lat <= cmd_be;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      _mpu_en      <= 1'b1;
      _mpu_rd      <= 1'b1;
      _mpu_wr      <= 1'b1;
      _mpu_be      <= 2'b11;
      mpu_addr     <= '0;
      mpu_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      _mpu_en   <= (state_d == IDLE);
      _mpu_rd   <= !((state_d == STROBE) && !wr_d);
      _mpu_wr   <= !((state_d == STROBE) &&  wr_d);
      _mpu_be   <= (state_d == IDLE) ? 2'b11 : ~be_d;
      rsp_valid <= (state != IDLE) && (state_d == IDLE);
      if (accept) begin
        mpu_addr <= addr_d;
        if (cmd_write) mpu_data_out <= cmd_data;
      end
      // Read data is sampled on the edge closing the last strobe cycle; it
      // stays put through HOLD until rsp_valid presents it.
      if (strobe_end) rsp_data <= wr_lat ? '0 : mpu_data_in;
    end
  end

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed testbench for mpu_bus_master: one default-timed instance and one
// instance with all timing parameters at 0.
module tb_mpu_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // default-parameter DUT
  logic        cmd_valid, cmd_ready, cmd_write, cmd_inc;
  logic [15:0] cmd_addr, cmd_data;
  logic [1:0]  cmd_be;
  logic        rsp_valid, busy, mpu_en_n, mpu_rd_n, mpu_wr_n;
  logic [15:0] rsp_data, mpu_addr, mpu_data_out, mpu_data_in;
  logic [1:0]  mpu_be_n;
  logic [15:0] model_data;

  // zero-timing DUT
  logic        cmd_valid0, cmd_ready0, rsp_valid0, busy0, en0_n, rd0_n, wr0_n;
  logic [15:0] rsp_data0, addr0, data_out0;
  logic [1:0]  be0_n;

  int n_checks = 0;
  int n_fail   = 0;

  // bus model: drives read data only while the read strobe is low
  assign mpu_data_in = !mpu_rd_n ? model_data : 16'hDEAD;

  mpu_bus_master u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be),
`ifdef MPU_MASTER_AUTOINC_EN
    .cmd_inc(cmd_inc),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    ._mpu_en(mpu_en_n), ._mpu_rd(mpu_rd_n), ._mpu_wr(mpu_wr_n), ._mpu_be(mpu_be_n),
    .mpu_addr(mpu_addr), .mpu_data_out(mpu_data_out), .mpu_data_in(mpu_data_in)
  );

  mpu_bus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(0), .HOLD_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(1'b1),
    .cmd_addr(16'h0040), .cmd_data(16'h5A5A), .cmd_be(2'b11),
`ifdef MPU_MASTER_AUTOINC_EN
    .cmd_inc(1'b0),
`endif
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
    ._mpu_en(en0_n), ._mpu_rd(rd0_n), ._mpu_wr(wr0_n), ._mpu_be(be0_n),
    .mpu_addr(addr0), .mpu_data_out(data_out0), .mpu_data_in(16'h0000)
  );

  // Drive one command for one accept edge; returns at the negedge of cycle 1.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic inc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_be = be; cmd_inc = inc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n} !== 5'b11111) begin
      n_fail++; $display("FAIL reset_bus got %b want 11111", {mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n});
    end
    n_checks++;
    if ({mpu_addr, mpu_data_out, rsp_data} !== 48'h0) begin
      n_fail++; $display("FAIL reset_regs got %h want 0", {mpu_addr, mpu_data_out, rsp_data});
    end
    n_checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_fail++; $display("FAIL reset_hs got %b want 010", {rsp_valid, cmd_ready, busy});
    end
  endtask

  // expected {en,rd,wr,be,rsp_valid} per cycle after the accept edge
  task automatic test_write;
    logic [5:0] exp;
    issue(1'b1, 16'h0200, 16'h1234, 2'b11, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      exp = {(k >= 1 && k <= 4) ? 1'b0 : 1'b1, 1'b1, (k == 2 || k == 3) ? 1'b0 : 1'b1,
             (k <= 4) ? 2'b00 : 2'b11, (k == 5)};
      n_checks++;
      if ({mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n, rsp_valid} !== exp) begin
        n_fail++; $display("FAIL write_cyc%0d got %b want %b", k, {mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n, rsp_valid}, exp);
      end
      if (k == 1) begin
        n_checks++;
        if ({mpu_addr, mpu_data_out} !== {16'h0200, 16'h1234}) begin
          n_fail++; $display("FAIL write_addr_data got %h want 02001234", {mpu_addr, mpu_data_out});
        end
      end
      if (k == 5) begin
        n_checks++;
        if ({rsp_data, cmd_ready} !== {16'h0000, 1'b1}) begin
          n_fail++; $display("FAIL write_rsp got %h want 00001", {rsp_data, cmd_ready});
        end
      end
    end
  endtask

  task automatic test_read;
    logic [5:0] exp;
    model_data = 16'hBEEF;
    issue(1'b0, 16'h0003, 16'hFFFF, 2'b01, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      exp = {(k <= 4) ? 1'b0 : 1'b1, (k == 2 || k == 3) ? 1'b0 : 1'b1, 1'b1,
             (k <= 4) ? 2'b10 : 2'b11, (k == 5)};
      n_checks++;
      if ({mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n, rsp_valid} !== exp) begin
        n_fail++; $display("FAIL read_cyc%0d got %b want %b", k, {mpu_en_n, mpu_rd_n, mpu_wr_n, mpu_be_n, rsp_valid}, exp);
      end
      if (k == 1) begin
        n_checks++;
        // a read leaves the write-data bus at its last written value
        if ({mpu_addr, mpu_data_out} !== {16'h0003, 16'h1234}) begin
          n_fail++; $display("FAIL read_addr got %h want 00031234", {mpu_addr, mpu_data_out});
        end
      end
      if (k == 5) begin
        n_checks++;
        if (rsp_data !== 16'hBEEF) begin
          n_fail++; $display("FAIL read_data got %h want beef", rsp_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_data = 16'hA001; cmd_be = 2'b11; cmd_inc = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      // {en, wr, ready, strobe overlap}
      exp = {(k % 5 == 0), !(k % 5 == 2 || k % 5 == 3), (k % 5 == 0), 1'b0};
      n_checks++;
      if ({mpu_en_n, mpu_wr_n, cmd_ready, (!mpu_rd_n && !mpu_wr_n)} !== exp) begin
        n_fail++; $display("FAIL b2b_cyc%0d got %b want %b", k, {mpu_en_n, mpu_wr_n, cmd_ready, (!mpu_rd_n && !mpu_wr_n)}, exp);
      end
      if (k % 5 == 1) begin
        n_checks++;
        if (mpu_addr !== 16'h0100 + 16'(k / 5)) begin
          n_fail++; $display("FAIL b2b_addr%0d got %h want %h", k, mpu_addr, 16'h0100 + 16'(k / 5));
        end
      end
      if (k % 5 == 0) cmd_addr = 16'h0100 + 16'(k / 5);
      if (k == 15) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_zero_timing;
    @(negedge clk);
    cmd_valid0 = 1'b1;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    n_checks++;
    if ({en0_n, rd0_n, wr0_n, be0_n, rsp_valid0} !== 6'b010000) begin
      n_fail++; $display("FAIL zero_cyc1 got %b want 010000", {en0_n, rd0_n, wr0_n, be0_n, rsp_valid0});
    end
    @(negedge clk);
    n_checks++;
    if ({en0_n, rd0_n, wr0_n, be0_n, rsp_valid0, cmd_ready0} !== 7'b1111111) begin
      n_fail++; $display("FAIL zero_cyc2 got %b want 1111111", {en0_n, rd0_n, wr0_n, be0_n, rsp_valid0, cmd_ready0});
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid0, addr0, data_out0} !== {1'b0, 16'h0040, 16'h5A5A}) begin
      n_fail++; $display("FAIL zero_cyc3 got %h want 0_0040_5a5a", {rsp_valid0, addr0, data_out0});
    end
  endtask

  task automatic test_reset_mid;
    model_data = 16'h7777;
    issue(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b0);
    @(negedge clk);
    n_checks++;
    if (mpu_rd_n !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_strobe got %b want 0", mpu_rd_n);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mpu_en_n, mpu_rd_n, mpu_wr_n, rsp_valid} !== 4'b1110) begin
      n_fail++; $display("FAIL rstmid_async got %b want 1110", {mpu_en_n, mpu_rd_n, mpu_wr_n, rsp_valid});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, mpu_en_n, cmd_ready} !== 3'b011) begin
        n_fail++; $display("FAIL rstmid_after%0d got %b want 011", k, {rsp_valid, mpu_en_n, cmd_ready});
      end
    end
  endtask

`ifdef MPU_MASTER_AUTOINC_EN
  task automatic test_autoinc;
    // immediately after reset the first incremented address is 1
    issue(1'b1, 16'h3333, 16'h0001, 2'b11, 1'b1);
    n_checks++;
    if (mpu_addr !== 16'h0001) begin
      n_fail++; $display("FAIL inc_after_reset got %h want 0001", mpu_addr);
    end
    repeat (4) @(negedge clk);
    issue(1'b1, 16'hFFFF, 16'h0002, 2'b11, 1'b0);
    repeat (4) @(negedge clk);
    issue(1'b1, 16'h1234, 16'h0003, 2'b11, 1'b1);
    n_checks++;
    if (mpu_addr !== 16'h0000) begin
      n_fail++; $display("FAIL inc_wrap got %h want 0000", mpu_addr);
    end
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_be = 2'b00; cmd_inc = 1'b0;
    cmd_valid0 = 1'b0;
    model_data = 16'h0000;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_write;
    test_read;
    test_back_to_back;
    test_zero_timing;
    test_reset_mid;
`ifdef MPU_MASTER_AUTOINC_EN
    test_autoinc;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
